shift_count_reg: RTL

- Parametrised multi-mode register. It is the successor to the single-bit reset/load flip-flop.
- Generalised to WIDTH bits, with eight operating modes: hold, parallel load, logical shift left/right, rotate left/right, increment and decrement.
- Provides a registered carry/shift-out bit and a zero flag.
- Used as the general-purpose accumulator, shift register and counter element in lab datapaths.

---
 rtl/shift_count_reg_if.sv | 13 +
 rtl/shift_count_reg.sv | 50 +++++
 2 files changed

// File: rtl/shift_count_reg_if.sv
// Operation bus of the multi-mode register: controls and data in, contents and flags out.
interface shift_count_reg_if #(parameter int WIDTH = 8);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             cout;
  logic             zero;

  modport master (output en, mode, d, sin, input q, cout, zero);
  modport slave  (input en, mode, d, sin, output q, cout, zero);
endinterface

// File: rtl/shift_count_reg.sv
// Multi-mode WIDTH-bit register: hold, load, shift, rotate, inc and dec, with registered
// carry/shift-out and a zero flag derived from q alone.
module shift_count_reg #(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] RESET_VAL = 32'd0
) (
  input logic              clk,
  input logic              reset,
  shift_count_reg_if.slave bus
);
  localparam int             M   = WIDTH - 1;
  localparam logic [WIDTH-1:0] RST = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] q, nxt, inc, dec;
  logic             cout, cnxt;
  logic [7:0]       ccand;

  assign inc = q + ONE;
  assign dec = q - ONE;

  // Per-bit 8:1 candidate mux indexed by mode, then the en hold mux.
  // Order (msb..lsb): dec, inc, ror, rol, shr, shl, load, hold.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [7:0] cand;
    assign cand = {dec[i], inc[i], q[(i+1)%WIDTH], q[(i+M)%WIDTH],
                   (i == M) ? bus.sin : q[(i+1)%WIDTH],
                   (i == 0) ? bus.sin : q[(i+M)%WIDTH],
                   bus.d[i], q[i]};
    assign nxt[i] = bus.en ? cand[bus.mode] : q[i];
  end

  // Carry is the wrap indicator for inc/dec and the bit leaving the register otherwise.
  assign ccand = {~|q, &q, q[0], q[M], q[0], q[M], 1'b0, cout};
  assign cnxt  = bus.en ? ccand[bus.mode] : cout;

  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= RST;
      cout <= 1'b0;
    end else begin
      q    <= nxt;
      cout <= cnxt;
    end
  end

  assign bus.q    = q;
  assign bus.cout = cout;
  assign bus.zero = ~|q;
endmodule
